axi_line_master: RTL and testbench
==================================

// Module: axi_line_master
// PURPOSE
//  AXI master that moves whole 128-bit cache lines as fixed 4-beat INCR bursts (32-bit beats).
//  Sits between the core-side line-refill/writeback logic and the AXI memory slaves.
//  One transaction at a time: a read fills the line; a write drains the line, then waits for B.
// PARAMETERS
//  WIDTH_ID     2    AXI ID width; all IDs driven 0
//  WIDTH_DA     32   AXI data width (fixed 32; line = 4*WIDTH_DA)
//  WIDTH_AD     32   AXI address width
//  TIMEOUT_CYC  256  idle cycles before abort (only with AXI_MASTER_TIMEOUT_EN)
// PORTS
//  M_AXI_ACLK        in   1     clock
//  M_AXI_ARESET      in   1     synchronous active-high reset
//  req_valid         in   1     line request valid
//  req_ready         out  1     =1 only in IDLE
//  req_we            in   1     1=write line, 0=read line
//  req_addr          in   AD    line address; bits [3:0] ignored
//  req_wline         in   4*DA  write line; beat k = [32k+31:32k]
//  rsp_valid         out  1     one-cycle completion pulse
//  rsp_rline         out  4*DA  read line; held until next read completes
//  rsp_err           out  1     valid with rsp_valid: xRESP!=0 or timeout
//  M_AXI_AWID/ARID   out  ID    constant 0
//  M_AXI_AWADDR/ARADDR out AD   {req_addr[AD-1:4],4'b0}, held per transaction
//  M_AXI_AWLEN/ARLEN out  4     constant 4'd3
//  M_AXI_AWSIZE/ARSIZE out 3    constant 3'b010
//  M_AXI_AWBURST/ARBURST out 2  constant 2'b01 (INCR)
//  M_AXI_AWVALID/AWREADY out/in 1  write address handshake
//  M_AXI_WDATA       out  DA    current write beat
//  M_AXI_WSTRB       out  DA/8  constant all ones
//  M_AXI_WLAST       out  1     =1 on beat 3 only
//  M_AXI_WVALID/WREADY out/in 1 write data handshake
//  M_AXI_BID/BRESP/BVALID in ID/2/1; M_AXI_BREADY out 1  write response
//  M_AXI_ARVALID/ARREADY out/in 1  read address handshake
//  M_AXI_RID/RDATA/RRESP/RLAST/RVALID in ID/DA/2/1/1; M_AXI_RREADY out 1
// BEHAVIOUR
//  - Reset: state IDLE; all VALID/READY outs 0; rsp_valid=0, rsp_err=0, rsp_rline=0; beat cnt=0.
//  - Reset mid-burst: next edge IDLE, valids drop; no rsp pulse; interrupted transaction lost.
//  - States: IDLE, AR, RD, AW, WR, BR, RSP.
//  - IDLE: req_valid&req_ready latches addr, we and wline; next is AW if we, else AR.
//  - AR: ARVALID=1 until ARREADY sampled high; then RD. Same for AW -> WR.
//  - RD: RREADY=1; each RVALID beat stores RDATA at line slot cnt; cnt++.
//    4th beat -> RSP. RLAST ignored; termination by count only.
//  - WR: WVALID=1, WDATA=line slot cnt; cnt++ on WREADY; WLAST=(cnt==3); 4th beat -> BR.
//    W is never issued before the AW handshake.
//  - BR: BREADY=1 until BVALID; then RSP.
//  - RSP: rsp_valid=1 for exactly 1 cycle; then IDLE.
//    rsp_err = OR of all RRESP/BRESP!=0 this transaction.
//  - VALID stable: once asserted, no AXI VALID or payload changes until its READY.
//  - Latency, zero-wait slave: read req accept -> rsp_valid = 7 cycles; write = 8 cycles.
//  - Requests arriving while req_ready=0 are not accepted; no queueing.
//  - cnt is 2 bits and wraps 3->0 on the last beat.
// CONFIGURATION
//  AXI_MASTER_TIMEOUT_EN defined:
//    - Counter clears on state entry and every AXI handshake.
//    - Counts in AR/RD/AW/WR/BR; reaching TIMEOUT_CYC aborts.
//    - Abort: all valids/readies drop next cycle, go RSP with rsp_err=1.
//    - Read abort leaves rsp_rline holding partial beats.
//  Not defined: no counter; master waits indefinitely in any state.
// TESTING
//  1 read 0x104, zero-wait slave beats 11,22,33,44 -> ARADDR=0x100, ARLEN=3, rsp_rline=44_33_22_11, err=0, 7 cyc.
//  2 write 0x200 line {D,C,B,A}, WREADY toggling 1/0 -> beats A,B,C,D in order, WLAST only on D, BREADY until B, err=0.
//  3 ARREADY held low 5 cycles -> ARVALID/ARADDR stable all 5 cycles; completes normally.
//  4 read with RRESP=2'b10 on beat 2 -> all 4 beats consumed, rsp_err=1.
//  5 reset asserted during WR beat 2 -> next cycle WVALID=0, IDLE, req_ready=1, no rsp_valid.
//  6 [TIMEOUT_EN, TIMEOUT_CYC=16] slave never asserts BVALID -> after 16 cycles rsp_valid=1, rsp_err=1, BREADY=0.

Source files
------------

// File: rtl/axi_line_master_if.sv
// AXI4 bus bundle used by axi_line_master.
// The master modport drives AW/W/AR and the B/R ready lines; the slave modport is the mirror.
interface axi_line_master_if #(
   parameter int WIDTH_ID = 2,
   parameter int WIDTH_DA = 32,
   parameter int WIDTH_AD = 32
);
   logic [WIDTH_ID-1:0]   M_AXI_AWID;
   logic [WIDTH_AD-1:0]   M_AXI_AWADDR;
   logic [3:0]            M_AXI_AWLEN;
   logic [2:0]            M_AXI_AWSIZE;
   logic [1:0]            M_AXI_AWBURST;
   logic                  M_AXI_AWVALID;
   logic                  M_AXI_AWREADY;
   logic [WIDTH_DA-1:0]   M_AXI_WDATA;
   logic [WIDTH_DA/8-1:0] M_AXI_WSTRB;
   logic                  M_AXI_WLAST;
   logic                  M_AXI_WVALID;
   logic                  M_AXI_WREADY;
   logic [WIDTH_ID-1:0]   M_AXI_BID;
   logic [1:0]            M_AXI_BRESP;
   logic                  M_AXI_BVALID;
   logic                  M_AXI_BREADY;
   logic [WIDTH_ID-1:0]   M_AXI_ARID;
   logic [WIDTH_AD-1:0]   M_AXI_ARADDR;
   logic [3:0]            M_AXI_ARLEN;
   logic [2:0]            M_AXI_ARSIZE;
   logic [1:0]            M_AXI_ARBURST;
   logic                  M_AXI_ARVALID;
   logic                  M_AXI_ARREADY;
   logic [WIDTH_ID-1:0]   M_AXI_RID;
   logic [WIDTH_DA-1:0]   M_AXI_RDATA;
   logic [1:0]            M_AXI_RRESP;
   logic                  M_AXI_RLAST;
   logic                  M_AXI_RVALID;
   logic                  M_AXI_RREADY;

   modport master (
      output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
      input  M_AXI_WREADY,
      input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
      output M_AXI_BREADY,
      output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
      output M_AXI_RREADY
   );

   modport slave (
      input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
      output M_AXI_WREADY,
      output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
      input  M_AXI_BREADY,
      input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
      input  M_AXI_RREADY
   );
endinterface

// File: rtl/axi_line_master.sv
// axi_line_master: moves one 128-bit cache line per request as a 4-beat INCR burst.
// Optional abort timer enabled by defining AXI_MASTER_TIMEOUT_EN.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | req_ready=1, waiting for a line request
//   AR     | read address offered (ARVALID)
//   RD     | collecting 4 read beats (RREADY)
//   AW     | write address offered (AWVALID)
//   WR     | driving 4 write beats (WVALID)
//   BR     | waiting for the write response (BREADY)
//   RSP    | one-cycle completion pulse on rsp_valid
module axi_line_master #(
   parameter int WIDTH_ID    = 2,
   parameter int WIDTH_DA    = 32,
   parameter int WIDTH_AD    = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                  M_AXI_ACLK,
   input  logic                  M_AXI_ARESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [WIDTH_AD-1:0]   req_addr,
   input  logic [4*WIDTH_DA-1:0] req_wline,
   output logic                  rsp_valid,
   output logic [4*WIDTH_DA-1:0] rsp_rline,
   output logic                  rsp_err,
   axi_line_master_if.master     m_axi
);

   typedef enum logic [2:0] {
      S_IDLE, S_AR, S_RD, S_AW, S_WR, S_BR, S_RSP
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [WIDTH_AD-1:0]       r_addr;
   logic [3:0][WIDTH_DA-1:0]  r_wline;
   logic [3:0][WIDTH_DA-1:0]  r_rline;
   logic [1:0]                r_cnt;
   logic                      r_err;

   logic w_req_hs;
   logic w_ar_hs;
   logic w_aw_hs;
   logic w_r_hs;
   logic w_w_hs;
   logic w_b_hs;
   logic w_any_hs;
   logic w_timeout;

   assign w_req_hs = (r_state == S_IDLE) && req_valid;
   assign w_ar_hs  = (r_state == S_AR) && m_axi.M_AXI_ARREADY;
   assign w_aw_hs  = (r_state == S_AW) && m_axi.M_AXI_AWREADY;
   assign w_r_hs   = (r_state == S_RD) && m_axi.M_AXI_RVALID;
   assign w_w_hs   = (r_state == S_WR) && m_axi.M_AXI_WREADY;
   assign w_b_hs   = (r_state == S_BR) && m_axi.M_AXI_BVALID;
   assign w_any_hs = w_ar_hs | w_aw_hs | w_r_hs | w_w_hs | w_b_hs;

   // Next-state decode; the burst ends on the beat count, never on RLAST.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (req_valid) w_next = req_we ? S_AW : S_AR;
         S_AR:   if (w_ar_hs) w_next = S_RD;
         S_RD:   if (w_r_hs && (r_cnt == 2'd3)) w_next = S_RSP;
         S_AW:   if (w_aw_hs) w_next = S_WR;
         S_WR:   if (w_w_hs && (r_cnt == 2'd3)) w_next = S_BR;
         S_BR:   if (w_b_hs) w_next = S_RSP;
         S_RSP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_timeout) w_next = S_RSP;
   end

   // State register.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) r_state <= S_IDLE;
      else              r_state <= w_next;
   end

   // Request capture, beat counter, read line assembly and sticky error.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         r_addr  <= '0;
         r_wline <= '0;
         r_rline <= '0;
         r_cnt   <= 2'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_req_hs) begin
            r_addr  <= {req_addr[WIDTH_AD-1:4], 4'b0000};
            r_wline <= req_wline;
            r_cnt   <= 2'd0;
            r_err   <= 1'b0;
         end
         if (w_r_hs) begin
            r_rline[r_cnt] <= m_axi.M_AXI_RDATA;
            r_cnt          <= r_cnt + 2'd1;
            if (m_axi.M_AXI_RRESP != 2'b00) r_err <= 1'b1;
         end
         if (w_w_hs) r_cnt <= r_cnt + 2'd1;
         if (w_b_hs && (m_axi.M_AXI_BRESP != 2'b00)) r_err <= 1'b1;
         if (w_timeout) begin
            r_err <= 1'b1;
            r_cnt <= 2'd0;
         end
      end
   end

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [TW-1:0] r_to_cnt;
   logic          w_to_active;
   logic          w_to_reload;

   assign w_to_active = (r_state == S_AR) || (r_state == S_RD) || (r_state == S_AW) ||
                        (r_state == S_WR) || (r_state == S_BR);
   assign w_to_reload = (w_next != r_state) || w_any_hs;
   assign w_timeout   = w_to_active && (r_to_cnt == '0) && !w_any_hs;

   // Down-counter: reloads on state entry or any handshake, aborts at zero.
   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET)                     r_to_cnt <= TW'(TIMEOUT_CYC - 1);
      else if (w_to_reload || !w_to_active) r_to_cnt <= TW'(TIMEOUT_CYC - 1);
      else if (r_to_cnt != '0)              r_to_cnt <= r_to_cnt - 1'b1;
   end
`else
   logic w_unused_to;
   assign w_timeout   = 1'b0;
   assign w_unused_to = (TIMEOUT_CYC == 0) | w_any_hs;
`endif

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = (r_state == S_RSP);
   assign rsp_err   = r_err;
   assign rsp_rline = r_rline;

   assign m_axi.M_AXI_AWID    = {WIDTH_ID{1'b0}};
   assign m_axi.M_AXI_AWADDR  = r_addr;
   assign m_axi.M_AXI_AWLEN   = 4'd3;
   assign m_axi.M_AXI_AWSIZE  = 3'b010;
   assign m_axi.M_AXI_AWBURST = 2'b01;
   assign m_axi.M_AXI_AWVALID = (r_state == S_AW);

   // WDATA/WLAST only move on a W handshake, so the payload stays stable while WVALID waits.
   assign m_axi.M_AXI_WDATA   = r_wline[r_cnt];
   assign m_axi.M_AXI_WSTRB   = {(WIDTH_DA/8){1'b1}};
   assign m_axi.M_AXI_WLAST   = (r_state == S_WR) && (r_cnt == 2'd3);
   assign m_axi.M_AXI_WVALID  = (r_state == S_WR);
   assign m_axi.M_AXI_BREADY  = (r_state == S_BR);

   assign m_axi.M_AXI_ARID    = {WIDTH_ID{1'b0}};
   assign m_axi.M_AXI_ARADDR  = r_addr;
   assign m_axi.M_AXI_ARLEN   = 4'd3;
   assign m_axi.M_AXI_ARSIZE  = 3'b010;
   assign m_axi.M_AXI_ARBURST = 2'b01;
   assign m_axi.M_AXI_ARVALID = (r_state == S_AR);
   assign m_axi.M_AXI_RREADY  = (r_state == S_RD);

   // IDs, RLAST and the in-line offset bits carry nothing this master acts on.
   logic w_unused;
   assign w_unused = ^{m_axi.M_AXI_BID, m_axi.M_AXI_RID, m_axi.M_AXI_RLAST, req_addr[3:0]};

endmodule

// File: tb/tb_axi_line_master.sv
// Directed plus randomized line transfers against a behavioural slave and line model.
module tb_axi_line_master;

`ifdef AXI_MASTER_TIMEOUT_EN
   localparam int TO_CYC = 16;
`else
   localparam int TO_CYC = 256;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [31:0]  req_addr;
   logic [127:0] req_wline;
   logic         rsp_valid;
   logic [127:0] rsp_rline;
   logic         rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   axi_line_master_if #(.WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32)) bus ();

   axi_line_master #(
      .WIDTH_ID(2), .WIDTH_DA(32), .WIDTH_AD(32), .TIMEOUT_CYC(TO_CYC)
   ) u_dut (
      .M_AXI_ACLK   (clk),
      .M_AXI_ARESET (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wline    (req_wline),
      .rsp_valid    (rsp_valid),
      .rsp_rline    (rsp_rline),
      .rsp_err      (rsp_err),
      .m_axi        (bus)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic slave_idle();
      bus.M_AXI_AWREADY = 1'b0;
      bus.M_AXI_WREADY  = 1'b0;
      bus.M_AXI_BID     = 2'd0;
      bus.M_AXI_BRESP   = 2'b00;
      bus.M_AXI_BVALID  = 1'b0;
      bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_RID     = 2'd0;
      bus.M_AXI_RDATA   = 32'd0;
      bus.M_AXI_RRESP   = 2'b00;
      bus.M_AXI_RLAST   = 1'b0;
      bus.M_AXI_RVALID  = 1'b0;
   endtask

   // One line transaction. mode: 0 zero-wait, 1 WREADY toggling, 2 random R/W readiness.
   // rl holds the slave's read beats (beat k at [32k+31:32k]); rerr marks beats answered SLVERR.
   task automatic txn(input string tag, input bit we, input logic [31:0] addr,
                      input logic [127:0] wl, input logic [127:0] rl, input logic [3:0] rerr,
                      input logic [1:0] bresp, input int a_hold, input int mode,
                      input int exp_lat, input int rst_beat, input bit no_b);
      int lat = 1;
      int a_wait = 0;
      int rk = 0;
      int wk = 0;
      bit a_done = 0, bpend = 0, done = 0, tog = 0, rst_now = 0;
      bit p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_wlast = 0;
      logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
      logic [31:0] line_addr;
      bit exp_err;
      line_addr = addr & ~32'hF;
      exp_err   = we ? ((bresp != 2'b00) || no_b) : (rerr != 4'b0000);

      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wline = wl;
      chk({tag, "_req_ready"}, req_ready, 1'b1);
      @(posedge clk); #1;
      lat++;
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_wline = {$urandom, $urandom, $urandom, $urandom};

      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         if (rsp_valid) begin
            chk({tag, "_err"}, rsp_err, exp_err);
            if (!we) chk({tag, "_rline"}, rsp_rline, rl);
            if (exp_lat > 0) chk({tag, "_latency"}, lat, exp_lat);
            chk({tag, "_beats"}, we ? wk : rk, 4);
            chk({tag, "_quiet"}, {bus.M_AXI_ARVALID, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                                  bus.M_AXI_RREADY, bus.M_AXI_BREADY}, 5'b0);
            done = 1;
         end else begin
            if (p_arv && !p_arr)
               chk({tag, "_ar_stable"}, {bus.M_AXI_ARVALID, bus.M_AXI_ARADDR}, {1'b1, p_araddr});
            if (p_awv && !p_awr)
               chk({tag, "_aw_stable"}, {bus.M_AXI_AWVALID, bus.M_AXI_AWADDR}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)
               chk({tag, "_w_stable"}, {bus.M_AXI_WVALID, bus.M_AXI_WLAST, bus.M_AXI_WDATA},
                   {1'b1, p_wlast, p_wdata});
            if (bus.M_AXI_WVALID) chk({tag, "_w_after_aw"}, a_done, 1'b1);

            bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (a_wait >= a_hold);
            bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (a_wait >= a_hold);
            if (bus.M_AXI_ARVALID || bus.M_AXI_AWVALID) a_wait++;
            bus.M_AXI_RVALID = !we && a_done && (rk < 4) && ((mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.M_AXI_RDATA  = bus.M_AXI_RVALID ? rl[32*rk +: 32] : $urandom;
            bus.M_AXI_RRESP  = (bus.M_AXI_RVALID && rerr[rk[1:0]]) ? 2'b10 : 2'b00;
            bus.M_AXI_RLAST  = bus.M_AXI_RVALID && (rk == 3);
            tog = ~tog;
            bus.M_AXI_WREADY = (mode == 0) ? 1'b1 : (mode == 1) ? tog : ($urandom_range(0, 1) == 1);
            bus.M_AXI_BVALID = bpend && !no_b;
            bus.M_AXI_BRESP  = bus.M_AXI_BVALID ? bresp : 2'b00;
            #1;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
               chk({tag, "_ar"}, {bus.M_AXI_ARID, bus.M_AXI_ARLEN, bus.M_AXI_ARSIZE,
                                  bus.M_AXI_ARBURST, bus.M_AXI_ARADDR},
                   {2'd0, 4'd3, 3'b010, 2'b01, line_addr});
               a_done = 1;
            end
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
               chk({tag, "_aw"}, {bus.M_AXI_AWID, bus.M_AXI_AWLEN, bus.M_AXI_AWSIZE,
                                  bus.M_AXI_AWBURST, bus.M_AXI_AWADDR},
                   {2'd0, 4'd3, 3'b010, 2'b01, line_addr});
               a_done = 1;
            end
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) rk++;
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
               chk({tag, "_w"}, {bus.M_AXI_WLAST, bus.M_AXI_WSTRB, bus.M_AXI_WDATA},
                   {wk == 3, 4'hF, wl[32*wk +: 32]});
               wk++;
               if (wk == 4) bpend = 1;
               if (wk == rst_beat) rst_now = 1;
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bpend = 0;
            p_arv = bus.M_AXI_ARVALID; p_arr = bus.M_AXI_ARREADY; p_araddr = bus.M_AXI_ARADDR;
            p_awv = bus.M_AXI_AWVALID; p_awr = bus.M_AXI_AWREADY; p_awaddr = bus.M_AXI_AWADDR;
            p_wv  = bus.M_AXI_WVALID;  p_wr  = bus.M_AXI_WREADY;
            p_wdata = bus.M_AXI_WDATA; p_wlast = bus.M_AXI_WLAST;
            if (rst_now) rst = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (rst_now) begin
               chk({tag, "_rst_wvalid"}, bus.M_AXI_WVALID, 1'b0);
               chk({tag, "_rst_ready"}, req_ready, 1'b1);
               chk({tag, "_rst_rsp"}, {rsp_valid, rsp_err}, 2'b00);
               rst = 1'b0;
               slave_idle();
               for (int k = 0; k < 3; k++) begin
                  @(posedge clk); #1;
                  chk({tag, "_rst_no_rsp"}, {rsp_valid, req_ready}, 2'b01);
               end
               return;
            end
         end
      end
      chk({tag, "_completed"}, done, 1'b1);
      slave_idle();
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, {rsp_valid, req_ready}, 2'b01);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] wl, rl;
      logic [3:0]   rerr;
      logic [1:0]   bresp;
      bit           we;

      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wline = '0;
      slave_idle();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", req_ready, 1'b1);
      chk("reset_valids", {bus.M_AXI_ARVALID, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
                           bus.M_AXI_RREADY, bus.M_AXI_BREADY}, 5'b0);
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_rline}, 130'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      rl = {32'h44, 32'h33, 32'h22, 32'h11};
      txn("t1_read", 0, 32'h0000_0104, 128'd0, rl, 4'b0000, 2'b00, 0, 0, 7, -1, 0);

      wl = {$urandom, $urandom, $urandom, $urandom};
      txn("t2_write_toggle", 1, 32'h0000_0200, wl, 128'd0, 4'b0000, 2'b00, 0, 1, -1, -1, 0);

      wl = {$urandom, $urandom, $urandom, $urandom};
      txn("t2b_write_zw", 1, 32'h0000_0A3C, wl, 128'd0, 4'b0000, 2'b00, 0, 0, 8, -1, 0);

      rl = {$urandom, $urandom, $urandom, $urandom};
      txn("t3_ar_stall", 0, 32'h0000_1238, 128'd0, rl, 4'b0000, 2'b00, 5, 0, 12, -1, 0);

      rl = {$urandom, $urandom, $urandom, $urandom};
      txn("t4_rresp", 0, 32'h0000_3000, 128'd0, rl, 4'b0100, 2'b00, 0, 0, 7, -1, 0);

      wl = {$urandom, $urandom, $urandom, $urandom};
      txn("t5_reset_mid", 1, 32'h0000_4440, wl, 128'd0, 4'b0000, 2'b00, 0, 0, -1, 2, 0);

      for (int i = 0; i < 8; i++) begin
         we    = ($urandom_range(0, 1) == 1);
         wl    = {$urandom, $urandom, $urandom, $urandom};
         rl    = {$urandom, $urandom, $urandom, $urandom};
         rerr  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
         bresp = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         txn("rand", we, $urandom, wl, rl, rerr, bresp, $urandom_range(0, 3), 2, -1, -1, 0);
      end

`ifdef AXI_MASTER_TIMEOUT_EN
      wl = {$urandom, $urandom, $urandom, $urandom};
      txn("t6_b_timeout", 1, 32'h0000_5000, wl, 128'd0, 4'b0000, 2'b00, 0, 0, 23, -1, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
